// File: rtl/ext_pkg.sv
// Shared constants for the load-data extender: size codes and skid-buffer
// occupancy states.
package ext_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer with a registered in_ready; payload is opaque.
module skid_buf
   import ext_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   state_t           state;
   logic [WIDTH-1:0] skid;
   logic             acc;
   logic             pop;

   assign acc = in_valid & in_ready;
   assign pop = out_valid & out_ready;

   // out_data always holds the oldest beat; skid only fills from ONE with no pop
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         skid      <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  out_data <= in_data;
               end else if (acc) begin
                  skid     <= in_data;
                  in_ready <= 1'b0;
                  state    <= ST_TWO;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  out_data <= skid;
                  in_ready <= 1'b1;
                  state    <= ST_ONE;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sign_ext_pipe.sv
// Streaming load-data extender: extracts a sized field at a byte offset,
// sign/zero-extends it and flags bad descriptors, then buffers the result.
module sign_ext_pipe
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SIZE_W = 2,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SIZE_W-1:0] in_size,
   input  logic [OFF_W-1:0]  in_off,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err
);

   localparam int unsigned DW = DATA_W;

   int unsigned       fw;
   int unsigned       off_b;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] ext;
   logic              sbit;
   logic              err;

   always_comb begin
      off_b = 32'(in_off) * 32'd8;
      fw    = 32'd8 << in_size;
      sh    = in_data >> off_b;
      sbit  = 1'b0;
      for (int unsigned i = 0; i < DW; i++) begin
         if (i + 1 == fw) sbit = sh[i];
      end
      // fields at least as wide as the word never enter the fill loop
      ext = sh;
      for (int unsigned i = 0; i < DW; i++) begin
         if (i >= fw) ext[i] = sbit & in_signed;
      end
      err = (fw > DW)
         || ((32'(in_off) & ((fw >> 3) - 32'd1)) != 32'd0)
         || (off_b + fw > DW);
   end

   skid_buf #(
      .WIDTH(DATA_W + 1)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  ({err, ext}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data ({out_err, out_data})
   );

endmodule

// File: tb/tb_sign_ext_pipe.sv
// Self-checking bench for sign_ext_pipe: directed literal vectors plus a
// queue-based reference model checked every cycle.
module tb_sign_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic [1:0]  in_off;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   int          nvec = 0;
   int          nerr = 0;
   logic [32:0] q[$];
   logic        last_acc;
   logic        comb_chk = 1'b0;

   sign_ext_pipe #(
      .DATA_W(32),
      .SIZE_W(2),
      .OFF_W (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_size  (in_size),
      .in_off   (in_off),
      .in_signed(in_signed),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_err  (out_err)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] model(logic [31:0] d, logic [1:0] sz,
                                         logic [1:0] off, logic sg);
      int          fw = 8 << sz;
      int          ob = 8 * int'(off);
      logic [63:0] sh, mask, res;
      logic        e;
      sh = 64'(d) >> ob;
      if (fw >= 32) res = sh;
      else begin
         mask = (64'd1 << fw) - 64'd1;
         res  = sh & mask;
         if (sg && sh[fw-1]) res = res | ~mask;
      end
      e = (fw > 32) || ((int'(off) % (fw / 8)) != 0) || (ob + fw > 32);
      return {e, res[31:0]};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic new_beat();
      in_data   = $urandom;
      in_size   = 2'($urandom_range(3));
      in_off    = 2'($urandom_range(3));
      in_signed = 1'($urandom_range(1));
   endtask

   // Inputs for this cycle are already driven; check outputs, advance model, clock.
   task automatic cycle();
      logic r0;
      logic pop;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) chk("out_beat", 64'({out_err, out_data}), 64'(q[0]));
      if (comb_chk) begin
         r0 = in_ready;
         out_ready = ~out_ready;
         #1;
         chk("in_ready_comb", 64'(in_ready), 64'(r0));
         out_ready = ~out_ready;
         #1;
      end
      last_acc = 1'b0;
      if (rst) q.delete();
      else begin
         last_acc = in_valid && in_ready;
         pop      = out_valid && out_ready;
         if (pop) void'(q.pop_front());
         if (last_acc) q.push_back(model(in_data, in_size, in_off, in_signed));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic directed(string name, logic [31:0] d, logic [1:0] sz, logic [1:0] off,
                           logic sg, logic [31:0] exp_d, logic exp_e);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_size   = sz;
      in_off    = off;
      in_signed = sg;
      cycle();
      in_valid = 1'b0;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_data"}, 64'(out_data), 64'(exp_d));
      chk({name, "_err"}, 64'(out_err), 64'(exp_e));
      cycle();
   endtask

   task automatic stream(input int n, input int pv, input int pr, input int stall,
                         input int max_cyc, output int cyc, output int sent_at_stall);
      int sent = 0;
      cyc = 0;
      sent_at_stall = 0;
      in_valid = 1'b0;
      while ((sent < n || q.size() > 0) && cyc < max_cyc) begin
         if (!in_valid && sent < n && int'($urandom_range(99)) < pv) begin
            new_beat();
            in_valid = 1'b1;
         end
         out_ready = (cyc < stall) ? 1'b0 : (int'($urandom_range(99)) < pr);
         if (cyc == stall) sent_at_stall = sent;
         cycle();
         cyc++;
         if (last_acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("stream_timeout", 64'(cyc >= max_cyc), 64'd0);
   endtask

   initial begin
      int cyc, sas;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      new_beat();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;

      directed("b_off0_s", 32'h1234_80FF, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      directed("b_off1_s", 32'h1234_80FF, 2'd0, 2'd1, 1'b1, 32'hFFFF_FF80, 1'b0);
      directed("b_off1_u", 32'h1234_80FF, 2'd0, 2'd1, 1'b0, 32'h0000_0080, 1'b0);
      directed("h_off2_s", 32'h8765_4321, 2'd1, 2'd2, 1'b1, 32'hFFFF_8765, 1'b0);
      directed("h_off1_s", 32'h8765_4321, 2'd1, 2'd1, 1'b1, 32'h0000_6543, 1'b1);
      directed("w_off0",   32'h8765_4321, 2'd2, 2'd0, 1'b1, 32'h8765_4321, 1'b0);
      directed("d_off0",   32'h8765_4321, 2'd3, 2'd0, 1'b1, 32'h8765_4321, 1'b1);
      directed("w_off1",   32'h8765_4321, 2'd2, 2'd1, 1'b0, 32'h0087_6543, 1'b1);
      directed("b_off3_s", 32'h8765_4321, 2'd0, 2'd3, 1'b1, 32'hFFFF_FF87, 1'b0);

      // Backpressure: 4 beats, sink stalled for the first 3 cycles
      stream(4, 100, 100, 3, 200, cyc, sas);
      chk("bp_accepted_in_stall", 64'(sas), 64'd2);

      // Full throughput: one beat per cycle plus one cycle of latency
      stream(100, 100, 100, 0, 1000, cyc, sas);
      chk("thru_cycles", 64'(cyc), 64'd101);

      // Reset while both entries are occupied
      out_ready = 1'b0;
      in_valid  = 1'b1;
      new_beat();
      cycle();
      new_beat();
      cycle();
      chk("fill_two_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      new_beat();
      cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_err", 64'(out_err), 64'd0);
      directed("post_rst", 32'h0000_FF00, 2'd0, 2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);

      // Random stress with the in_ready/out_ready isolation probe enabled
      comb_chk = 1'b1;
      stream(10000, 70, 60, 0, 60000, cyc, sas);
      comb_chk = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sign_ext_pipe.md
# sign_ext_pipe

Streaming load-data extender: accepts a DATA_W-bit word and a (size, byte offset, signedness) descriptor, extracts the addressed field, and sign- or zero-extends it to DATA_W bits. It is the parametrised, run-time-configurable successor of the combinational fixed-width sign extender. It sits between the memory read-data return and the register-file writeback path. A valid/ready handshake with a 2-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `DATA_W`, 32: data width in bits; a multiple of 8 and ≥ 16.
- `SIZE_W`, 2: width of the size code; field width = 8 << size.
- `OFF_W`, $clog2(DATA_W/8): width of the byte offset.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W  raw word.
- `in_size`  in  SIZE_W  field size code (0=B, 1=H, 2=W, 3=D).
- `in_off`  in  OFF_W  byte offset of the field LSB within `in_data`.
- `in_signed`  in  1  1 = sign-extend, 0 = zero-extend.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  output beat consumed when `out_valid && out_ready`.
- `out_data`  out  DATA_W  extended result.
- `out_err`  out  1  descriptor error flag, qualified by `out_valid`.

## Operation
- Datapath, evaluated on acceptance:
  - `sh = in_data >> (8*in_off)`, zero-filled.
  - `fw = 8 << in_size`.
  - If `fw >= DATA_W`, the result is `sh` unchanged.
  - Otherwise, bits `[fw-1:0]` come from `sh`, and bits `[DATA_W-1:fw]` take `sh[fw-1] & in_signed`.
- `out_err` = 1 under any of these conditions:
  - `fw > DATA_W` (oversize);
  - `in_off` is not a multiple of `fw/8` (misaligned);
  - `in_off*8 + fw > DATA_W` (overrun).
- On error, `out_data` is still the value computed above; the beat is never dropped.
- Beats leave in acceptance order; no reordering or merging.
- Control FSM on occupancy:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - ONE: `out_valid=1`, `in_ready=1`.
  - TWO: `out_valid=1`, `in_ready=0`.
- FSM transitions (acc = input accepted, pop = output consumed):
  - EMPTY → ONE on acc.
  - ONE → TWO on acc & !pop.
  - ONE → EMPTY on pop & !acc.
  - ONE → ONE on acc & pop.
  - TWO → ONE on pop.
  - Every other combination holds the current state.
- In TWO, the output register holds the older beat and the skid register the newer one. On pop, the skid beat moves to the output register.

## Timing
- Latency: a beat accepted at edge N is presented on `out_*` after edge N; `out_valid` is high in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready` stays high.
- `in_ready` is a register output with no combinational path from `out_ready`. It falls the cycle after the skid register fills and rises the cycle after a pop from TWO.
- `out_data`/`out_err` are stable while `out_valid && !out_ready`.
- Reset: when `rst` is sampled high at an edge, the following hold after that edge regardless of in-flight beats:
  - state = EMPTY;
  - `out_valid=0`, `in_ready=1`;
  - `out_data=0`, `out_err=0`;
  - skid contents discarded.
- A beat presented in the reset cycle is not accepted.
- Simultaneous acc and pop in ONE: the new beat replaces the output register in the same edge, with no bubble.

## Structure
- Shared package `ext_pkg` holds:
  - size codes SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3;
  - FSM state encodings ST_EMPTY, ST_ONE, ST_TWO.
- Sub-module `skid_buf` (parameter WIDTH) contains the 2-entry valid/ready buffer and FSM. It carries `{out_err, out_data}` as an opaque payload.
- The extract/extend/error datapath is combinational, sits in `sign_ext_pipe` ahead of `skid_buf`, and is reusable standalone.

## Test plan
All scenarios use DATA_W=32.
- Byte extraction, `in_data=0x1234_80FF`, `out_ready=1`:
  - size=B, off=0, signed → `0xFFFF_FFFF`, err=0;
  - size=B, off=1, signed → `0xFFFF_FF80`;
  - size=B, off=1, unsigned → `0x0000_0080`.
- `in_data=0x8765_4321`:
  - size=H, off=2, signed → `0xFFFF_8765`;
  - size=H, off=1 → err=1, data `0x0000_6543` (sign bit 0).
  - size=W, off=0 → `0x8765_4321`, err=0.
  - size=D, off=0 → err=1, data passthrough.
- Backpressure: stream 4 beats with `out_ready=0` for 3 cycles, then 1.
  - `in_ready` drops after 2 acceptances.
  - Outputs appear in order, with none lost or duplicated.
  - `out_data` is held stable while stalled.
- Full throughput: 100 random beats with `in_valid=out_ready=1` → one output per cycle, 1-cycle latency, results match a reference model.
- Reset mid-stream: assert `rst` for 1 cycle while in TWO → next cycle `out_valid=0`, `in_ready=1`, `out_data=0`; the first beat after reset emerges correctly.
- Random stress: random `in_valid`/`out_ready`, size, off and sign over 10k beats → scoreboard match, and `in_ready` never depends combinationally on `out_ready`.
